// File: rtl/vec_mag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_mag_pkg
// Description : Shared types and width helpers for the vector-magnitude engine.
//               State encoding for the handshake FSM and derived-width
//               functions used by vec_magnitude_iter and isqrt_iter.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_mag_pkg;

    // Handshake FSM states, explicit 2-bit encoding
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        ROOT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Width of x^2 + y^2 for W-bit unsigned operands
    function automatic int sum_w(input int w);
        return 2 * w + 1;
    endfunction

    // Width of the magnitude: sqrt(2)*(2^W-1) < 2^(W+1)
    function automatic int out_w(input int w);
        return w + 1;
    endfunction

    // Width of a bit index that can address every root bit
    function automatic int idx_w(input int ow);
        return (ow > 2) ? $clog2(ow) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_iter.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_iter
// Description : Bit-serial integer square root. Loads an operand on i_start,
//               then resolves one root bit per cycle from the MSB down.
//               o_rem always holds operand - root^2 for the bits resolved so
//               far; o_done pulses for one cycle after the last bit.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_iter
    import vec_mag_pkg::*;
#(
    parameter int SUM_W = 17,
    parameter int OUT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [SUM_W-1:0] i_sum,
    output logic             o_done,
    output logic [OUT_W-1:0] o_root,
    output logic [SUM_W-1:0] o_rem
);

    localparam int               K_W      = idx_w(OUT_W);
    localparam int               D_W      = 2 * OUT_W;
    localparam logic [K_W-1:0]   c_K_LAST = K_W'(OUT_W - 1);

    logic             r_active;
    logic [K_W-1:0]   r_k;
    logic [SUM_W-1:0] r_rem;
    logic [OUT_W-1:0] r_root;
    logic             r_done;

    logic [K_W:0]     w_k_plus1;
    logic [D_W-1:0]   w_root_ext;
    logic [D_W-1:0]   w_rem_ext;
    logic [D_W-1:0]   w_delta;
    logic [OUT_W-1:0] w_bit;
    logic             w_take;

    // Setting bit k grows root^2 by (root << (k+1)) + (1 << 2k); take the bit
    // when that increment still fits inside the remaining remainder
    always_comb begin
        w_k_plus1  = {1'b0, r_k} + (K_W+1)'(1);
        w_root_ext = {{(D_W-OUT_W){1'b0}}, r_root};
        w_rem_ext  = {{(D_W-SUM_W){1'b0}}, r_rem};
        w_delta    = (w_root_ext << w_k_plus1) + (D_W'(1) << {r_k, 1'b0});
        w_take     = (w_delta <= w_rem_ext);
        w_bit      = OUT_W'(1) << r_k;
    end

    // Load on start, then one restoring step per cycle until bit 0 is done
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= 1'b0;
            r_k      <= '0;
            r_rem    <= '0;
            r_root   <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_active <= 1'b1;
                r_k      <= c_K_LAST;
                r_rem    <= i_sum;
                r_root   <= '0;
            end else if (r_active) begin
                if (w_take) begin
                    r_rem  <= r_rem - w_delta[SUM_W-1:0];
                    r_root <= r_root | w_bit;
                end
                if (r_k == '0) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                end else begin
                    r_k <= r_k - K_W'(1);
                end
            end
        end
    end

    assign o_done = r_done;
    assign o_root = r_root;
    assign o_rem  = r_rem;

endmodule
`default_nettype wire

// File: rtl/vec_magnitude_iter.sv
`default_nettype none
// ============================================================================
// Module      : vec_magnitude_iter
// Description : Euclidean magnitude floor(sqrt(x^2 + y^2)) of two unsigned
//               W-bit operands, valid/ready on both sides, one operation in
//               flight. Optional round-to-nearest when VEC_MAG_ROUND_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_magnitude_iter
    import vec_mag_pkg::*;
#(
    parameter  int W     = 8,
    localparam int SUM_W = sum_w(W),
    localparam int OUT_W = out_w(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] mag,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_x;
    logic [W-1:0]     r_y;
    logic [OUT_W-1:0] r_mag;

    logic [2*W-1:0]   w_xx;
    logic [2*W-1:0]   w_yy;
    logic [SUM_W-1:0] w_sum;
    logic             w_start;
    logic             w_root_done;
    logic [OUT_W-1:0] w_root;
    logic [SUM_W-1:0] w_rem;
    logic [OUT_W-1:0] w_result;

    // Full-width sum of squares; fed to the root engine during SQUARE
    always_comb begin
        w_xx  = {{W{1'b0}}, r_x} * {{W{1'b0}}, r_x};
        w_yy  = {{W{1'b0}}, r_y} * {{W{1'b0}}, r_y};
        w_sum = {1'b0, w_xx} + {1'b0, w_yy};
    end

    isqrt_iter #(
        .SUM_W (SUM_W),
        .OUT_W (OUT_W)
    ) u_isqrt (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_sum   (w_sum),
        .o_done  (w_root_done),
        .o_root  (w_root),
        .o_rem   (w_rem)
    );

`ifdef VEC_MAG_ROUND_EN
    logic w_round_up;

    // Round to nearest: sum - root^2 > root means sqrt(sum) >= root + 0.5
    always_comb begin
        w_round_up = ({{(SUM_W-OUT_W){1'b0}}, w_root} < w_rem);
        w_result   = w_root + {{(OUT_W-1){1'b0}}, w_round_up};
    end
`else
    logic w_unused_rem;

    // Truncating build: the final remainder is not needed
    always_comb begin
        w_result = w_root;
    end
    assign w_unused_rem = ^w_rem;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: one pass IDLE -> SQUARE -> ROOT -> DONE, held in DONE by backpressure
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_next = SQUARE;
            SQUARE:                   w_next = ROOT;
            ROOT:    if (w_root_done) w_next = DONE;
            DONE:    if (out_ready)   w_next = IDLE;
            default:                  w_next = IDLE;
        endcase
    end

    // State-decoded handshake outputs and root-engine start
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_start   = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            SQUARE:  w_start   = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture on acceptance, result capture on DONE entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_mag <= '0;
        end else begin
            if (in_valid && in_ready) begin
                r_x <= x;
                r_y <= y;
            end
            if ((r_state == ROOT) && w_root_done) begin
                r_mag <= w_result;
            end
        end
    end

    assign mag = r_mag;

endmodule
`default_nettype wire

// File: tb/tb_vec_magnitude_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_magnitude_iter
// Description : Self-checking bench for vec_magnitude_iter (W=8 and W=4).
//               Results are compared against an arithmetic sqrt reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_magnitude_iter;

    localparam int W      = 8;
    localparam int OUT_W  = W + 1;
    localparam int LAT    = OUT_W + 2;
    localparam int W4     = 4;
    localparam int OUT_W4 = W4 + 1;
    localparam int LAT4   = OUT_W4 + 2;

`ifdef VEC_MAG_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              in_valid, in_ready, out_valid, out_ready, busy;
    logic [W-1:0]      x, y;
    logic [OUT_W-1:0]  mag;

    logic              in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [W4-1:0]     x4, y4;
    logic [OUT_W4-1:0] mag4;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_mag  = 0;

    vec_magnitude_iter #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
        .mag(mag), .busy(busy)
    );

    vec_magnitude_iter #(.W(W4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .x(x4), .y(y4), .out_valid(out_valid4), .out_ready(out_ready4),
        .mag(mag4), .busy(busy4)
    );

    // Reference: largest r with r*r <= x^2+y^2, optionally rounded to nearest
    function automatic int model_mag(input int a, input int b);
        int s = a * a + b * b;
        int r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        if (ROUND && (s - r * r > r)) r++;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare process: track accepted operands, check every presented result
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (in_valid === 1'b1 && in_ready === 1'b1)
                exp_mag = model_mag(int'(x), int'(y));
            if (out_valid === 1'b1)
                check("mag_vs_model", 32'(mag), 32'(exp_mag));
            if (busy === 1'b1)
                check("in_ready_while_busy", 32'(in_ready), 32'd0);
        end
    end

    // One W=8 operation with latency check; lit < 0 means no literal expectation
    task automatic run_op(input int a, input int b, input int lit);
        int n;
        x        = a[W-1:0];
        y        = b[W-1:0];
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 4 * LAT) begin tick(); n++; end
        check("latency", 32'(n), 32'(LAT));
        if (lit >= 0) check("mag_literal", 32'(mag), 32'(lit));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
    endtask

    // One W=4 operation checked directly against the reference
    task automatic run_op4(input int a, input int b);
        int n;
        x4        = a[W4-1:0];
        y4        = b[W4-1:0];
        in_valid4 = 1'b1;
        n = 0;
        while (in_ready4 !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        in_valid4 = 1'b0;
        n = 0;
        while (out_valid4 !== 1'b1 && n < 4 * LAT4) begin tick(); n++; end
        check("w4_latency", 32'(n), 32'(LAT4));
        check("w4_mag", 32'(mag4), 32'(model_mag(a, b)));
        out_ready4 = 1'b1;
        tick();
        out_ready4 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OUT_W-1:0] held;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; x4 = '0; y4 = '0;

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mag", 32'(mag), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors with hand-computed results
        run_op(3, 4, 5);
        run_op(255, 255, ROUND ? 361 : 360);
        run_op(2, 3, ROUND ? 4 : 3);
        run_op(0, 0, 0);
        run_op(5, 5, 7);

        // Backpressure: DONE holds, in_valid during busy is ignored
        x = 8'd7; y = 8'd9; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 4 * LAT) begin tick(); n++; end
        check("bp_latency", 32'(n), 32'(LAT));
        check("bp_mag_literal", 32'(mag), 32'd11);
        held = mag;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin x = 8'd1; y = 8'd1; in_valid = 1'b1; end
            else if (i == 8) in_valid = 1'b0;
            tick();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_mag_stable", 32'(mag), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_release", 32'(out_valid), 32'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            check("bp_not_queued", 32'(busy), 32'd0);
        end

        // Reset during ROOT aborts the operation
        x = 8'd9; y = 8'd12; in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        check("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_mag", 32'(mag), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();
        run_op(6, 8, 10);

        // Random pairs
        for (int i = 0; i < 300; i++)
            run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), -1);

        // Exhaustive W=4 sweep
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_op4(a, b);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
